// File: rtl/multi_port_regfile_pkg.sv
// Shared types for the multi-port register file.
//   rf_cfg_t       : default geometry (depth, width, read/write port counts)
//   clear_state_t  : clear-sweep FSM states
//   data_t/index_t : legacy fixed-width operand types
package multi_port_regfile_pkg;

  typedef struct packed {
    int unsigned depth;
    int unsigned width;
    int unsigned num_rd;
    int unsigned num_wr;
  } rf_cfg_t;

  localparam rf_cfg_t RF_CFG_DEFAULT = '{depth: 32, width: 32, num_rd: 2, num_wr: 1};

  typedef enum logic {
    IDLE,
    SWEEP
  } clear_state_t;

  typedef logic [31:0] data_t;
  typedef logic [4:0]  index_t;

endpackage

// File: rtl/multi_port_regfile_clear_ctrl.sv
// Clear-sweep controller: on a clear pulse, walks every entry once, one per cycle.
// Ports:
//   clock, reset : posedge clock, synchronous active-high reset
//   clear        : start pulse (ignored while a sweep is running)
//   busy         : sweep in progress (high for exactly DEPTH cycles)
//   clr_we       : zero-write strobe for entry clr_idx
//   clr_idx      : entry being cleared this cycle
module regfile_clear_ctrl
  import multi_port_regfile_pkg::*;
#(
  parameter  int DEPTH = 32,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  output logic             busy,
  output logic             clr_we,
  output logic [IDX_W-1:0] clr_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  clear_state_t     state, state_nxt;
  logic [IDX_W-1:0] cnt, cnt_nxt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy      = 1'b0;
    clr_we    = 1'b0;
    clr_idx   = cnt;
    case (state)
      IDLE: begin
        if (clear) begin
          state_nxt = SWEEP;
          cnt_nxt   = '0;
        end
      end
      SWEEP: begin
        busy   = 1'b1;
        clr_we = 1'b1;
        if (cnt == LAST_IDX) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/multi_port_regfile.sv
// Parametrised NUM_RD-read / NUM_WR-write register file with registered reads,
// highest-port-wins multi-write, a hardware clear sweep and write-conflict flag.
// Optional feature macro: MULTI_PORT_REGFILE_BYPASS_EN (same-edge write->read bypass).
// Ports:
//   clock, reset   : posedge clock, synchronous active-high reset
//   I_We           : per-port write enable          [NUM_WR]
//   I_Index_Dst    : per-port write index           [NUM_WR*IDX_W]
//   I_Data         : per-port write data            [NUM_WR*WIDTH]
//   I_Re           : per-port read enable           [NUM_RD]
//   I_Index_Src    : per-port read index            [NUM_RD*IDX_W]
//   O_Data_Src     : per-port registered read data  [NUM_RD*WIDTH]
//   I_Clear        : pulse to start clear sweep
//   O_Busy         : clear sweep in progress
//   O_Wr_Conflict  : registered, two or more writers hit one index last cycle
module multi_port_regfile
  import multi_port_regfile_pkg::*;
#(
  parameter  int DEPTH  = int'(RF_CFG_DEFAULT.depth),
  parameter  int WIDTH  = int'(RF_CFG_DEFAULT.width),
  parameter  int NUM_RD = int'(RF_CFG_DEFAULT.num_rd),
  parameter  int NUM_WR = int'(RF_CFG_DEFAULT.num_wr),
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_WR-1:0]       I_We,
  input  logic [NUM_WR*IDX_W-1:0] I_Index_Dst,
  input  logic [NUM_WR*WIDTH-1:0] I_Data,
  input  logic [NUM_RD-1:0]       I_Re,
  input  logic [NUM_RD*IDX_W-1:0] I_Index_Src,
  output logic [NUM_RD*WIDTH-1:0] O_Data_Src,
  input  logic                    I_Clear,
  output logic                    O_Busy,
  output logic                    O_Wr_Conflict
);

  logic [WIDTH-1:0] mem [DEPTH];

  logic             busy, clr_we;
  logic [IDX_W-1:0] clr_idx;

  logic [IDX_W-1:0] wr_idx [NUM_WR];
  logic [WIDTH-1:0] wr_data [NUM_WR];
  logic [NUM_WR-1:0] wr_ok;
  logic [IDX_W-1:0] rd_idx [NUM_RD];
  logic [NUM_RD-1:0] rd_valid;
  logic             conflict;

  regfile_clear_ctrl #(.DEPTH(DEPTH)) u_clear_ctrl (
    .clock   (clock),
    .reset   (reset),
    .clear   (I_Clear),
    .busy    (busy),
    .clr_we  (clr_we),
    .clr_idx (clr_idx)
  );

  assign O_Busy = busy;

  // Writes are accepted only outside a sweep and only for in-range indices.
  always_comb begin
    conflict = 1'b0;
    for (int unsigned w = 0; w < NUM_WR; w++) begin
      wr_idx[w]  = I_Index_Dst[w*IDX_W +: IDX_W];
      wr_data[w] = I_Data[w*WIDTH +: WIDTH];
      wr_ok[w]   = I_We[w] && !busy && (int'(wr_idx[w]) < DEPTH);
    end
    for (int unsigned i = 0; i < NUM_WR; i++) begin
      for (int unsigned j = i + 1; j < NUM_WR; j++) begin
        if (wr_ok[i] && wr_ok[j] && (wr_idx[i] == wr_idx[j])) conflict = 1'b1;
      end
    end
    for (int unsigned r = 0; r < NUM_RD; r++) begin
      rd_idx[r]   = I_Index_Src[r*IDX_W +: IDX_W];
      rd_valid[r] = int'(rd_idx[r]) < DEPTH;
    end
  end

`ifdef MULTI_PORT_REGFILE_BYPASS_EN
  logic [NUM_RD-1:0] byp_hit;
  logic [WIDTH-1:0]  byp_data [NUM_RD];

  // Ascending port scan so the highest-numbered matching writer is forwarded,
  // mirroring the storage priority. The sweep zero-write takes precedence.
  always_comb begin
    for (int unsigned r = 0; r < NUM_RD; r++) begin
      byp_hit[r]  = 1'b0;
      byp_data[r] = '0;
      if (clr_we && (rd_idx[r] == clr_idx)) begin
        byp_hit[r] = 1'b1;
      end else begin
        for (int unsigned w = 0; w < NUM_WR; w++) begin
          if (wr_ok[w] && (wr_idx[w] == rd_idx[r])) begin
            byp_hit[r]  = 1'b1;
            byp_data[r] = wr_data[w];
          end
        end
      end
    end
  end
`endif

  // Storage: later loop iterations override earlier ones, so the highest port wins.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned e = 0; e < DEPTH; e++) mem[e] <= '0;
    end else if (clr_we) begin
      mem[clr_idx] <= '0;
    end else begin
      for (int unsigned w = 0; w < NUM_WR; w++) begin
        if (wr_ok[w]) mem[wr_idx[w]] <= wr_data[w];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      O_Data_Src    <= '0;
      O_Wr_Conflict <= 1'b0;
    end else begin
      O_Wr_Conflict <= conflict;
      for (int unsigned r = 0; r < NUM_RD; r++) begin
        if (I_Re[r]) begin
          if (!rd_valid[r]) begin
            O_Data_Src[r*WIDTH +: WIDTH] <= '0;
`ifdef MULTI_PORT_REGFILE_BYPASS_EN
          end else if (byp_hit[r]) begin
            O_Data_Src[r*WIDTH +: WIDTH] <= byp_data[r];
`endif
          end else begin
            O_Data_Src[r*WIDTH +: WIDTH] <= mem[rd_idx[r]];
          end
        end
      end
    end
  end

endmodule
